// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings and level constants for the divider issue controller.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_WAIT  = 2'd1,
        CTRL_DONE  = 2'd2,
        CTRL_DRAIN = 2'd3
    } ctrl_state_t;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        DIV_START        = 1'b1;
    localparam logic        DIV_STOP         = 1'b0;
    localparam logic        DIV_RESULT_READY = 1'b1;

    // Divider result layout is {remainder, quotient}.
    function automatic logic [31:0] result_hi(input logic [63:0] r);
        return r[63:32];
    endfunction

    function automatic logic [31:0] result_lo(input logic [63:0] r);
        return r[31:0];
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/stall controller for the multi-cycle radix-2 divider.
// Optional build macro DIV_ZERO_FASTPATH_EN: zero divisors bypass the divider.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid_i,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stallreq_o,
    output logic        res_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    ctrl_state_t      state_reg;
    logic [CNT_W-1:0] drain_cnt_reg;
    logic             start_reg;
    logic             annul_reg;
    logic             signed_reg;
    logic [31:0]      op1_reg;
    logic [31:0]      op2_reg;
    logic             res_valid_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic             zero_fast;

`ifdef DIV_ZERO_FASTPATH_EN
    assign zero_fast = (op2_i == ZERO_WORD);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= CTRL_IDLE;
            drain_cnt_reg <= '0;
            start_reg     <= DIV_STOP;
            annul_reg     <= 1'b0;
            signed_reg    <= 1'b0;
            op1_reg       <= ZERO_WORD;
            op2_reg       <= ZERO_WORD;
            res_valid_reg <= 1'b0;
            hi_reg        <= ZERO_WORD;
            lo_reg        <= ZERO_WORD;
        end else begin
            case (state_reg)
                CTRL_IDLE: begin
                    if (div_valid_i && !flush_i) begin
                        signed_reg <= div_signed_i;
                        op1_reg    <= op1_i;
                        op2_reg    <= op2_i;
                        if (zero_fast) begin
                            hi_reg        <= ZERO_WORD;
                            lo_reg        <= ZERO_WORD;
                            res_valid_reg <= 1'b1;
                            state_reg     <= CTRL_DONE;
                        end else begin
                            start_reg <= DIV_START;
                            state_reg <= CTRL_WAIT;
                        end
                    end
                end
                CTRL_WAIT: begin
                    // Flush wins over a coincident ready; that result is dropped.
                    if (flush_i) begin
                        start_reg     <= DIV_STOP;
                        annul_reg     <= 1'b1;
                        drain_cnt_reg <= CNT_W'(DRAIN_CYCLES);
                        state_reg     <= CTRL_DRAIN;
                    end else if (div_ready_i == DIV_RESULT_READY) begin
                        hi_reg        <= result_hi(div_result_i);
                        lo_reg        <= result_lo(div_result_i);
                        res_valid_reg <= 1'b1;
                        start_reg     <= DIV_STOP;
                        state_reg     <= CTRL_DONE;
                    end
                end
                CTRL_DONE: begin
                    if (flush_i || !hold_i) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= CTRL_IDLE;
                    end
                end
                CTRL_DRAIN: begin
                    if (drain_cnt_reg <= CNT_W'(1)) begin
                        annul_reg     <= 1'b0;
                        drain_cnt_reg <= '0;
                        state_reg     <= CTRL_IDLE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= CTRL_IDLE;
            endcase
        end
    end

    // Only the stall request is combinational so a fresh DIV stalls in its first EX cycle.
    assign stallreq_o = ((state_reg == CTRL_IDLE) && div_valid_i && !flush_i && !zero_fast)
                      || (state_reg == CTRL_WAIT)
                      || ((state_reg == CTRL_DRAIN) && div_valid_i);

    assign div_start_o  = start_reg;
    assign div_annul_o  = annul_reg;
    assign div_signed_o = signed_reg;
    assign div_op1_o    = op1_reg;
    assign div_op2_o    = op2_reg;
    assign res_valid_o  = res_valid_reg;
    assign hi_o         = hi_reg;
    assign lo_o         = lo_reg;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage initiator for the multi-cycle radix-2 divider. Issues DIV/DIVU operations and holds operands stable for the whole operation. Requests a pipeline stall until the divider reports ready.
- Presents the 64-bit quotient/remainder as HI/LO write data. Returns the divider to its free state on completion or flush.
- Sits between the EX stage, the pipeline controller (stall/flush) and the divider.

Parameters:
DRAIN_CYCLES, 2, cycles start=0/annul=1 are held after a flush before a new issue.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
div_valid_i  in  1  DIV/DIVU present in EX
div_signed_i  in  1  1=DIV, 0=DIVU
op1_i  in  32  dividend (rs)
op2_i  in  32  divisor (rt)
flush_i  in  1  kill EX instruction
hold_i  in  1  downstream stall; EX instruction does not advance
div_ready_i  in  1  divider result valid
div_result_i  in  64  {remainder, quotient}
div_start_o  out  1  divider start, level, held until ready
div_annul_o  out  1  divider annul
div_signed_o  out  1  latched signed flag
div_op1_o  out  32  latched dividend
div_op2_o  out  32  latched divisor
stallreq_o  out  1  stall request to pipeline control
res_valid_o  out  1  hi_o/lo_o valid for EX instruction
hi_o  out  32  remainder
lo_o  out  32  quotient

Behaviour:
- Reset: state IDLE; all outputs 0; drain counter 0.
- States: IDLE, WAIT, DONE, DRAIN. All outputs are registered except stallreq_o.
- stallreq_o = (IDLE & div_valid_i & ~flush_i) | WAIT | (DRAIN & div_valid_i).
- IDLE:
  - On div_valid_i & ~flush_i: latch signed/op1/op2, set div_start_o=1, go to WAIT.
  - Otherwise remain.
- WAIT:
  - div_start_o=1. div_op1_o, div_op2_o and div_signed_o must not change, because the divider re-reads them for sign fix-up.
  - If flush_i: start<=0, annul<=1, counter<=DRAIN_CYCLES, go to DRAIN. Flush has priority over ready in the same cycle; the result is discarded.
  - Else if div_ready_i: capture hi<=result[63:32], lo<=result[31:0], res_valid<=1, start<=0, go to DONE.
- DONE:
  - start=0, so the divider returns to free at the end of the first DONE cycle.
  - res_valid_o held while hold_i=1.
  - If flush_i: res_valid<=0, go to IDLE.
  - Else if ~hold_i: res_valid<=0, go to IDLE; the instruction advances with hi/lo this cycle.
- DRAIN:
  - start=0, annul=1. Counter decrements each cycle.
  - At counter==1: annul<=0, go to IDLE.
  - A new div_valid_i is stalled, not issued.
- Back-to-back DIVs: the second issue occurs in the IDLE cycle after DONE. The divider is already free at that point, so no extra bubble is inserted.
- hold_i has no effect in IDLE/WAIT; the instruction is stalled there anyway.
- Divide-by-zero is passed to the divider, which returns 0 after its short path. HI=LO=0.
- Reset mid-operation: returns to IDLE with start=0. The divider shares rst.

Optional Feature:
DIV_ZERO_FASTPATH_EN:
- With the macro: in IDLE, op2_i==0 with div_valid_i & ~flush_i goes directly to DONE with hi=lo=0 and res_valid=1. start is never asserted and there is no stall cycle.
- Without the macro: divide-by-zero goes through the divider as above.

Decomposition:
- Shared package/defines: state encodings (CTRL_IDLE/WAIT/DONE/DRAIN), `ZeroWord, DivStart/DivStop and DivResultReady levels.
- No sub-module; the divider is instantiated beside this block, not inside it.

Test Plan:
- DIVU 100/7 against the divider model → start high ~35 cycles, stallreq_o high throughout; DONE gives hi=2, lo=14, res_valid 1 cycle; start low.
- DIV -7/2 → hi=0xFFFFFFFF, lo=0xFFFFFFFD. div_op1_o/op2_o constant from issue until ready.
- flush_i in WAIT cycle 10 → annul high 2 cycles, start 0, no res_valid. A DIV presented during DRAIN stalls, then issues in IDLE.
- Ready and flush_i in the same cycle → result discarded, state DRAIN.
- hold_i=1 for 3 cycles in DONE → res_valid_o/hi/lo stable 3+1 cycles. A back-to-back second DIV issues the next cycle.
- 5/0: without the macro → hi=lo=0 via the divider. With DIV_ZERO_FASTPATH_EN → res_valid the next cycle, start never 1.
